// File: rtl/bus_pkg.sv
// Shared bus types: transfer size, slave FSM states, request payload and byte-enable helper.
package bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_BE = BUS_DW / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } bus_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } bus_slv_state_t;

    typedef struct packed {
        logic              wr;
        logic [BUS_AW-1:0] addr;
        bus_size_t         size;
        logic [BUS_DW-1:0] wdata;
    } bus_req_t;

    // Lane mask for a transfer at natural byte lanes; illegal size enables nothing.
    function automatic logic [BUS_BE-1:0] be_from_size(input bus_size_t size, input logic [1:0] lo);
        case (size)
            SIZE_B:  return 4'(4'b0001 << lo);
            SIZE_H:  return 4'(4'b0011 << lo);
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bus_if.sv
// Core memory bus: master holds a request stable until a one-cycle ack from the slave.
interface bus_if;

    logic                 req;
    logic                 wr;
    logic [31:0]          addr;
    bus_pkg::bus_size_t   size;
    logic [31:0]          wdata;
    logic                 ack;
    logic                 err;
    logic [31:0]          rdata;

    modport master (output req, wr, addr, size, wdata, input ack, err, rdata);
    modport slave  (input req, wr, addr, size, wdata, output ack, err, rdata);

endinterface

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables, read-first.
module sp_ram_be #(
    parameter int unsigned DEPTH     = 1024,
    parameter              INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_mem_slave.sv
// Bus slave backing a byte-writable RAM region with range/alignment checks and fixed wait states.
module bus_mem_slave
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter              INIT_FILE   = ""
) (
    input logic  clk,
    input logic  rst_n,
    bus_if.slave bus
);

    localparam int unsigned AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] REGION_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_slv_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    bus_req_t       req_q, req_d, cur;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           rdv_q, rdv_d;

    logic [31:0]    off;
    logic           fault;
    logic [3:0]     be;
    logic [AW-1:0]  ram_addr;
    logic           ram_en;
    logic [3:0]     ram_we;
    logic [31:0]    ram_rdata;

    // In IDLE the live bus request is decoded so a zero-wait read can hit the RAM immediately.
    always_comb begin
        if (state_q == IDLE) begin
            cur.wr    = bus.wr;
            cur.addr  = bus.addr;
            cur.size  = bus.size;
            cur.wdata = bus.wdata;
        end else begin
            cur = req_q;
        end
        off      = cur.addr - BASE_ADDR;
        fault    = (off >= REGION_BYTES)
                || (cur.size == SIZE_X)
                || ((cur.size == SIZE_H) && cur.addr[0])
                || ((cur.size == SIZE_W) && (cur.addr[1:0] != 2'b00));
        be       = be_from_size(cur.size, cur.addr[1:0]);
        ram_addr = off[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdv_d   = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 4'b0000;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    req_d = cur;
                    cnt_d = WAIT_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (cur.wr && !fault) begin
                    ram_en = 1'b1;
                    ram_we = be;
                end
            end
            default: state_d = IDLE;
        endcase

        // Last cycle before RESP: register the response and fetch read data.
        if ((state_d == RESP) && (state_q != RESP)) begin
            ack_d = 1'b1;
            err_d = fault;
            rdv_d = !cur.wr && !fault;
            if (rdv_d) begin
                ram_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
        end
    end

    sp_ram_be #(
        .DEPTH     (DEPTH_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdv_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench: one slave with one wait state, one with zero wait states.
module tb_bus_mem_slave;
    import bus_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    bus_if b1();
    bus_if b0();

    bus_mem_slave #(
        .BASE_ADDR   (32'h0000_0000),
        .DEPTH_WORDS (1024),
        .WAIT_STATES (1),
        .INIT_FILE   ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    bus_mem_slave #(
        .BASE_ADDR   (32'h0000_0000),
        .DEPTH_WORDS (1024),
        .WAIT_STATES (0),
        .INIT_FILE   ("")
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel, input logic req, input logic wr, input logic [31:0] addr,
                         input bus_size_t size, input logic [31:0] wdata);
        if (sel) begin
            b1.req = req; b1.wr = wr; b1.addr = addr; b1.size = size; b1.wdata = wdata;
        end else begin
            b0.req = req; b0.wr = wr; b0.addr = addr; b0.size = size; b0.wdata = wdata;
        end
    endtask

    // Issue one request from an IDLE cycle; lat counts clock edges until ack is seen.
    task automatic txn(input bit sel, input logic wr, input logic [31:0] addr, input bus_size_t size,
                       input logic [31:0] wdata, output int lat, output logic err, output logic [31:0] rdata);
        logic got;
        got = 1'b0; lat = 0; err = 1'b0; rdata = 32'h0;
        drive(sel, 1'b1, wr, addr, size, wdata);
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (sel ? b1.ack : b0.ack) begin
                got   = 1'b1;
                err   = sel ? b1.err : b0.err;
                rdata = sel ? b1.rdata : b0.rdata;
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, SIZE_W, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, SIZE_W, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, SIZE_W, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b1.ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", b1.ack); end
        checks++; if (b1.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", b1.err); end
        checks++; if (b1.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", b1.rdata); end
        checks++; if (b0.ack !== 1'b0) begin errors++; $display("FAIL rst_ack0: got %b expected 0", b0.ack); end
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b1.ack !== 1'b0 || b0.ack !== 1'b0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL idle_no_ack: got %0d acks expected 0", n); end
    endtask

    task automatic test_word_rw();
        int lat; logic err; logic [31:0] rd;
        txn(1, 1'b1, 32'h10, SIZE_W, 32'hDEADBEEF, lat, err, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d expected 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rd); end
        txn(1, 1'b0, 32'h10, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d expected 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", err); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_half();
        int lat; logic err; logic [31:0] rd;
        txn(1, 1'b1, 32'h13, SIZE_B, 32'hAA00_0000, lat, err, rd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL byte_err: got %b expected 0", err); end
        txn(1, 1'b1, 32'h10, SIZE_H, 32'h0000_1234, lat, err, rd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL half_err: got %b expected 0", err); end
        txn(1, 1'b0, 32'h10, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (rd !== 32'hAAAD1234) begin errors++; $display("FAIL merge: got %h expected aaad1234", rd); end
    endtask

    task automatic test_faults();
        int lat; logic err; logic [31:0] rd;
        txn(1, 1'b1, 32'h11, SIZE_H, 32'hFFFF_FFFF, lat, err, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mis_half_lat: got %0d expected 2", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_half_err: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_half_rdata: got %h expected 0", rd); end
        txn(1, 1'b1, 32'h12, SIZE_X, 32'hFFFF_FFFF, lat, err, rd);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL size_x_err: got %b expected 1", err); end
        txn(1, 1'b0, 32'h12, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_word_err: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_word_rdata: got %h expected 0", rd); end
        txn(1, 1'b0, 32'h10, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (rd !== 32'hAAAD1234) begin errors++; $display("FAIL unchanged: got %h expected aaad1234", rd); end
    endtask

    task automatic test_range();
        int lat; logic err; logic [31:0] rd;
        txn(1, 1'b1, 32'h0000_1000, SIZE_W, 32'h1234_5678, lat, err, rd);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL past_end_err: got %b expected 1", err); end
        txn(1, 1'b0, 32'hFFFF_FFFC, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL below_base_err: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL below_base_rdata: got %h expected 0", rd); end
        txn(1, 1'b1, 32'h0000_0FFC, SIZE_W, 32'h0BAD_F00D, lat, err, rd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_wr_err: got %b expected 0", err); end
        txn(1, 1'b0, 32'h0000_0FFC, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_rd_err: got %b expected 0", err); end
        checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL last_rd: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic err; logic [31:0] rd; int n;
        txn(1, 1'b1, 32'h20, SIZE_W, 32'h5A5A_5A5A, lat, err, rd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pre_wr_err: got %b expected 0", err); end
        drive(1, 1'b1, 1'b1, 32'h20, SIZE_W, 32'h1111_1111);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        drive(1, 1'b0, 1'b0, 32'h0, SIZE_W, 32'h0);
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (b1.ack !== 1'b0) n++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (n !== 0) begin errors++; $display("FAIL mid_rst_ack: got %0d acks expected 0", n); end
        txn(1, 1'b0, 32'h20, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_rst_lat: got %0d expected 2", lat); end
        checks++; if (rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL post_rst_rd: got %h expected 5a5a5a5a", rd); end
    endtask

    // Zero wait states, req held high: write, read-after-write, write; acks every other cycle.
    task automatic test_back_to_back();
        int lat; logic err; logic [31:0] rd; int n;
        logic exp_ack;
        n = 0;
        drive(0, 1'b1, 1'b1, 32'h40, SIZE_W, 32'hA000_0001);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            exp_ack = (k % 2 == 0);
            checks++;
            if (b0.ack !== exp_ack) begin
                errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", k, b0.ack, exp_ack);
            end
            if (b0.ack === 1'b1) begin
                n++;
                if (n == 2) begin
                    checks++;
                    if (b0.rdata !== 32'hA000_0001) begin
                        errors++; $display("FAIL b2b_raw: got %h expected a0000001", b0.rdata);
                    end
                end
                if (n == 1) drive(0, 1'b1, 1'b0, 32'h40, SIZE_W, 32'h0);
                else if (n == 2) drive(0, 1'b1, 1'b1, 32'h44, SIZE_W, 32'hA000_0002);
                else drive(0, 1'b0, 1'b0, 32'h0, SIZE_W, 32'h0);
            end
        end
        txn(0, 1'b0, 32'h44, SIZE_W, 32'h0, lat, err, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_lat: got %0d expected 1", lat); end
        checks++; if (rd !== 32'hA000_0002) begin errors++; $display("FAIL ws0_rd: got %h expected a0000002", rd); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_faults();
        test_range();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
